// File: rtl/slave_port_pkg.sv
// Shared definitions for the serial-bus burst slave port.
//   state_t       : FSM state encodings, IDLE..RDATA
//   ADDR_BEATS    : lane beats needed to carry the address field
//   LEN_BEATS     : lane beats needed to carry the burst length field
//   DATA_BEATS    : lane beats needed to carry one data word
//   MAX3          : largest of three beat counts (sizes the beat counter)
package slave_port_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    LEN,
    WDATA,
    WMEM,
    SPLIT,
    RREQ,
    RWAIT,
    RDATA
  } state_t;

  function automatic int ADDR_BEATS(input int addr_width, input int ser_width);
    return addr_width / ser_width;
  endfunction

  function automatic int LEN_BEATS(input int len_width, input int ser_width);
    return len_width / ser_width;
  endfunction

  function automatic int DATA_BEATS(input int data_width, input int ser_width);
    return data_width / ser_width;
  endfunction

  function automatic int MAX3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// LSB-beat-first lane shift register with parallel load and parallel read.
//   clk, rst   : clock, synchronous active-high clear
//   shift_in   : new beat din enters at the top, so after WIDTH/LANE beats
//                the first beat sits in the least significant lane
//   shift_out  : drop the low lane (already sent), zero-fill from the top
//   load       : parallel load of pdata (highest priority after rst)
//   q          : parallel contents; q[LANE-1:0] is the current outgoing beat
module ser_shift_reg #(
  parameter int WIDTH = 8,
  parameter int LANE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic             load,
  input  logic [LANE-1:0]  din,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] q_out;

  // A one-beat field has nothing to shift through.
  generate
    if (WIDTH == LANE) begin : g_single
      assign q_in  = din;
      assign q_out = '0;
    end else begin : g_multi
      assign q_in  = {din, q[WIDTH-1:LANE]};
      assign q_out = {{LANE{1'b0}}, q[WIDTH-1:LANE]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)            q <= '0;
    else if (load)      q <= pdata;
    else if (shift_in)  q <= q_in;
    else if (shift_out) q <= q_out;
  end

endmodule

// File: rtl/slave_port_burst.sv
// Serial-bus burst slave port. Deserialises address, burst length and write
// data from the master lane, drives one slave memory, and serialises read
// data back with back-pressure. Optional split hold before reads and an idle
// timeout on the receive phases.
//   clk, rst               : clock, synchronous active-high reset
//   swdata, smode, mvalid  : master beat, transfer mode (1 write), beat valid
//   mready                 : master accepts the current srdata beat
//   srdata, svalid         : read data beat and its valid
//   sready, ssplit         : port idle / port in split hold
//   smemwen, smemren       : one-cycle memory write / read strobes
//   smemaddr, smemwdata    : memory address / write word
//   smemrdata              : memory read word, valid MEM_LAT cycles after smemren
module slave_port_burst
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int SER_WIDTH    = 1,
  parameter int LEN_WIDTH    = 4,
  parameter int SPLIT_EN     = 0,
  parameter int SPLIT_CYCLES = 4,
  parameter int MEM_LAT      = 1,
  parameter int TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  input  logic [SER_WIDTH-1:0]  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  input  logic                  mready,
  output logic [SER_WIDTH-1:0]  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit
);

  localparam int AB   = ADDR_BEATS(ADDR_WIDTH, SER_WIDTH);
  localparam int LB   = LEN_BEATS(LEN_WIDTH, SER_WIDTH);
  localparam int DB   = DATA_BEATS(DATA_WIDTH, SER_WIDTH);
  localparam int BW   = $clog2(MAX3(AB, LB, DB)) + 1;
  localparam int WW   = LEN_WIDTH + 1;
  localparam int LW   = $clog2(MEM_LAT) + 1;
  localparam int SW   = $clog2(SPLIT_CYCLES) + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;

  localparam logic [BW-1:0] AB_LAST    = BW'(AB - 1);
  localparam logic [BW-1:0] LB_LAST    = BW'(LB - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DB - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] SPLIT_LAST = SW'(SPLIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  state_t state, state_nxt;
  logic                  mode;
  logic [BW-1:0]         beat_cnt, beat_last;
  logic [WW-1:0]         word_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [SW-1:0]         split_cnt;
  logic [TW-1:0]         to_cnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic rx_phase, fld_done, last_word, timeout, beat_adv, word_adv;
  logic addr_shift, addr_load, len_shift, data_shift, data_load, data_out;

  assign addr_inc  = addr_q + ADDR_WIDTH'(1);   // wraps naturally
  assign rx_phase  = (state == ADDR) || (state == LEN) || (state == WDATA);
  // to_cnt holds the low cycles already seen; this cycle is the TIMEOUT-th
  assign timeout   = rx_phase && !mvalid && (to_cnt == TO_LAST);
  assign last_word = (word_cnt == {1'b0, len_q});
  assign fld_done  = (beat_cnt == beat_last);

  always_comb begin
    case (state)
      LEN:          beat_last = LB_LAST;
      WDATA, RDATA: beat_last = DB_LAST;
      default:      beat_last = AB_LAST;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    addr_shift = 1'b0;
    addr_load  = 1'b0;
    len_shift  = 1'b0;
    data_shift = 1'b0;
    data_load  = 1'b0;
    data_out   = 1'b0;
    beat_adv   = 1'b0;
    word_adv   = 1'b0;
    case (state)
      IDLE: if (mvalid) begin
        addr_shift = 1'b1;
        state_nxt  = ADDR;
      end
      ADDR: if (timeout) state_nxt = IDLE;
        else if (mvalid) begin
          addr_shift = 1'b1;
          beat_adv   = 1'b1;
          if (fld_done) state_nxt = LEN;
        end
      LEN: if (timeout) state_nxt = IDLE;
        else if (mvalid) begin
          len_shift = 1'b1;
          beat_adv  = 1'b1;
          if (fld_done)
            state_nxt = mode ? WDATA : ((SPLIT_EN != 0) ? SPLIT : RREQ);
        end
      WDATA: if (timeout) state_nxt = IDLE;
        else if (mvalid) begin
          data_shift = 1'b1;
          beat_adv   = 1'b1;
          if (fld_done) state_nxt = WMEM;
        end
      WMEM: begin
        addr_load = 1'b1;
        word_adv  = 1'b1;
        state_nxt = last_word ? IDLE : WDATA;
      end
      SPLIT: if (split_cnt == SPLIT_LAST) state_nxt = RREQ;
      RREQ:  state_nxt = RWAIT;
      RWAIT: if (lat_cnt == LAT_LAST) begin
        data_load = 1'b1;
        state_nxt = RDATA;
      end
      RDATA: if (mready) begin
        data_out = 1'b1;
        beat_adv = 1'b1;
        if (fld_done) begin
          word_adv = 1'b1;
          if (last_word) state_nxt = IDLE;
          else begin
            addr_load = 1'b1;
            state_nxt = RREQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      beat_cnt  <= '0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
      split_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mvalid) mode <= smode;
      // Address beat 0 is taken in IDLE, so ADDR starts with one beat in hand.
      if (state_nxt != state)  beat_cnt <= (state == IDLE) ? BW'(1) : '0;
      else if (beat_adv)       beat_cnt <= beat_cnt + BW'(1);
      if (state == IDLE)       word_cnt <= '0;
      else if (word_adv)       word_cnt <= word_cnt + WW'(1);
      lat_cnt   <= (state == RWAIT && state_nxt == RWAIT) ? lat_cnt + LW'(1) : '0;
      split_cnt <= (state == SPLIT && state_nxt == SPLIT) ? split_cnt + SW'(1) : '0;
      to_cnt    <= (rx_phase && !mvalid && state_nxt == state) ? to_cnt + TW'(1) : '0;
    end
  end

  ser_shift_reg #(.WIDTH(ADDR_WIDTH), .LANE(SER_WIDTH)) u_addr (
    .clk(clk), .rst(rst), .shift_in(addr_shift), .shift_out(1'b0),
    .load(addr_load), .din(swdata), .pdata(addr_inc), .q(addr_q)
  );

  ser_shift_reg #(.WIDTH(LEN_WIDTH), .LANE(SER_WIDTH)) u_len (
    .clk(clk), .rst(rst), .shift_in(len_shift), .shift_out(1'b0),
    .load(1'b0), .din(swdata), .pdata({LEN_WIDTH{1'b0}}), .q(len_q)
  );

  // One data register serves both directions: write words shift in,
  // read words load in parallel and shift out.
  ser_shift_reg #(.WIDTH(DATA_WIDTH), .LANE(SER_WIDTH)) u_data (
    .clk(clk), .rst(rst), .shift_in(data_shift), .shift_out(data_out),
    .load(data_load), .din(swdata), .pdata(smemrdata), .q(data_q)
  );

  // Strobes are masked by rst so nothing fires in a reset cycle.
  assign smemwen   = (state == WMEM) && !rst;
  assign smemren   = (state == RREQ) && !rst;
  assign smemaddr  = (state == WMEM || state == RREQ) ? addr_q : '0;
  assign smemwdata = (state == WMEM) ? data_q : '0;
  assign srdata    = (state == RDATA) ? data_q[SER_WIDTH-1:0] : '0;
  assign svalid    = (state == RDATA);
  assign sready    = (state == IDLE);
  assign ssplit    = (state == SPLIT);

endmodule
